keypad_debouncer: RTL and testbench

Front end of the combination-lock datapath: it takes the raw 20-button push-button bus, synchronises it, and debounces presses and releases. For each accepted single-key press it emits exactly one `key_valid` pulse with a 5-bit key code. Optionally it generates typematic repeats for digit keys. Downstream password, display-enable and controller logic run on `clk` and use `key_valid` as a clock enable, never as a clock.

---
 rtl/keypad_debouncer_pkg.sv | 29 ++
 rtl/keypad_debouncer_if.sv | 36 +++
 rtl/keypad_debouncer_key_onehot_enc.sv | 40 ++++
 rtl/keypad_debouncer.sv | 199 +++++++++++++++++++
 tb/tb_keypad_debouncer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// keypad_debouncer_pkg
// Shared definitions for the combination-lock keypad front end:
//   - bus widths (PB_W raw buttons, KEY_W key code)
//   - key-code constants (KEY_ENTER, KEY_BACK)
//   - debouncer FSM state encodings
//   - small constant helper used for counter sizing
// ---------------------------------------------------------------------------
package keypad_debouncer_pkg;

  localparam int KEY_W = 5;
  localparam int PB_W  = 20;

  // Codes 0x00-0x0F are hex digits; everything from ENTER upward is a
  // command or spare key and never auto-repeats.
  localparam logic [KEY_W-1:0] KEY_ENTER = 5'h10;
  localparam logic [KEY_W-1:0] KEY_BACK  = 5'h11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Larger of two integers, for sizing the shared repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// ---------------------------------------------------------------------------
// keypad_debouncer_if
// Bundle between the push-button source and the debouncer.
//   pb        : raw active-high buttons (source -> debouncer)
//   key_valid : one-cycle accepted press / repeat strobe
//   key_code  : index of accepted button, held between strobes
//   key_held  : accepted key currently in HELD or RELEASE
//   multi_err : more than one synchronised button set
// master = button source / consumer side, slave = debouncer.
// ---------------------------------------------------------------------------
interface keypad_debouncer_if;
  import keypad_debouncer_pkg::*;

  logic [PB_W-1:0]  pb;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_held;
  logic             multi_err;

  modport master (
    output pb,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  multi_err
  );

  modport slave (
    input  pb,
    output key_valid,
    output key_code,
    output key_held,
    output multi_err
  );

endinterface

// File: rtl/keypad_debouncer_key_onehot_enc.sv
// ---------------------------------------------------------------------------
// key_onehot_enc
// Combinational 20-to-5 encoder.
//   vec  : synchronised button vector
//   one  : exactly one bit of vec set
//   none : vec is zero
//   idx  : index of the set bit (meaningful only when one is high)
// ---------------------------------------------------------------------------
module key_onehot_enc
  import keypad_debouncer_pkg::*;
(
  input  logic [PB_W-1:0]  vec,
  output logic             one,
  output logic             none,
  output logic [KEY_W-1:0] idx
);

  logic [1:0] hits_s;  // number of set bits, saturating at 2

  // Count set bits (saturating) and record the position of a set bit.
  always_comb begin
    hits_s = 2'd0;
    idx    = {KEY_W{1'b0}};
    for (int i = 0; i < PB_W; i++) begin
      if (vec[i]) begin
        idx = KEY_W'(i);
        if (hits_s != 2'd2) begin
          hits_s = hits_s + 2'd1;
        end else begin
          hits_s = hits_s;
        end
      end else begin
        idx = idx;
      end
    end
    one  = (hits_s == 2'd1);
    none = (hits_s == 2'd0);
  end

endmodule

// File: rtl/keypad_debouncer.sv
// ---------------------------------------------------------------------------
// keypad_debouncer
// Synchronises the raw push-button bus, debounces presses and releases,
// and emits one key_valid strobe per accepted single-key press, plus
// optional typematic repeats for held digit keys.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   kp    : keypad_debouncer_if.slave (pb in; key_valid, key_code,
//           key_held, multi_err out, all registered)
// ---------------------------------------------------------------------------
module keypad_debouncer
  import keypad_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic              clk,
  input  logic              reset,
  keypad_debouncer_if.slave kp
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [CNT_W:0]    DEB_C   = (CNT_W + 1)'(DEBOUNCE_CYCLES);
  localparam logic [RCNT_W-1:0] DELAY_C = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RATE_C  = RCNT_W'(REPEAT_RATE);
  localparam logic              REP_ON  = (REPEAT_EN != 0);
  // With a single required sample the first stable observation already
  // completes the debounce, so the intermediate states are skipped.
  localparam logic              DEB_ONE = (DEBOUNCE_CYCLES <= 1);

  logic [PB_W-1:0]   sync1_r, sync2_r;
  logic              one_s, none_s;
  logic [KEY_W-1:0]  idx_s;

  logic [1:0]        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [CNT_W:0]    cnt_inc_s;
  logic [RCNT_W-1:0] rcnt_r, rcnt_nxt_s, rcnt_inc_s, rep_target_s;
  logic              rep_phase_r, rep_phase_nxt_s;  // 0: initial delay, 1: rate
  logic [KEY_W-1:0]  cand_r, cand_nxt_s;
  logic              key_valid_r, key_valid_nxt_s;
  logic [KEY_W-1:0]  key_code_r, key_code_nxt_s;
  logic              key_held_r, key_held_nxt_s;
  logic              multi_err_r;

  // Two-flop synchroniser for the asynchronous button bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {PB_W{1'b0}};
      sync2_r <= {PB_W{1'b0}};
    end else begin
      sync1_r <= kp.pb;
      sync2_r <= sync1_r;
    end
  end

  key_onehot_enc u_enc (
    .vec  (sync2_r),
    .one  (one_s),
    .none (none_s),
    .idx  (idx_s)
  );

  assign cnt_inc_s    = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  assign rcnt_inc_s   = (rcnt_r == {RCNT_W{1'b1}}) ? rcnt_r : (rcnt_r + {{(RCNT_W-1){1'b0}}, 1'b1});
  assign rep_target_s = rep_phase_r ? RATE_C : DELAY_C;

  // Debounce / hold / release state machine, next-state and strobe logic.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    rcnt_nxt_s      = rcnt_r;
    rep_phase_nxt_s = rep_phase_r;
    cand_nxt_s      = cand_r;
    key_valid_nxt_s = 1'b0;
    key_code_nxt_s  = key_code_r;

    case (state_r)
      ST_IDLE: begin
        if (one_s) begin
          cand_nxt_s = idx_s;
          if (DEB_ONE) begin
            key_valid_nxt_s = 1'b1;
            key_code_nxt_s  = idx_s;
            rcnt_nxt_s      = {RCNT_W{1'b0}};
            rep_phase_nxt_s = 1'b0;
            cnt_nxt_s       = {CNT_W{1'b0}};
            state_nxt_s     = ST_HELD;
          end else begin
            cnt_nxt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
            state_nxt_s = ST_DEBOUNCE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_DEBOUNCE: begin
        if (one_s && (idx_s == cand_r)) begin
          if (cnt_inc_s >= DEB_C) begin
            key_valid_nxt_s = 1'b1;
            key_code_nxt_s  = cand_r;
            rcnt_nxt_s      = {RCNT_W{1'b0}};
            rep_phase_nxt_s = 1'b0;
            cnt_nxt_s       = {CNT_W{1'b0}};
            state_nxt_s     = ST_HELD;
          end else begin
            cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
          end
        end else begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end
      end

      ST_HELD: begin
        if (none_s) begin
          if (DEB_ONE) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
            state_nxt_s = ST_RELEASE;
          end
        end else if (REP_ON && (cand_r < KEY_ENTER)) begin
          // Typematic: first strobe after the delay, then every rate period.
          if (rcnt_inc_s == rep_target_s) begin
            key_valid_nxt_s = 1'b1;
            key_code_nxt_s  = cand_r;
            rcnt_nxt_s      = {RCNT_W{1'b0}};
            rep_phase_nxt_s = 1'b1;
          end else begin
            rcnt_nxt_s = rcnt_inc_s;
          end
        end else begin
          state_nxt_s = ST_HELD;
        end
      end

      ST_RELEASE: begin
        if (none_s) begin
          if (cnt_inc_s >= DEB_C) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
          end
        end else begin
          // Release bounce: resume holding, repeat timing preserved.
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_HELD;
        end
      end

      default: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase

    key_held_nxt_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_RELEASE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rcnt_r      <= {RCNT_W{1'b0}};
      rep_phase_r <= 1'b0;
      cand_r      <= {KEY_W{1'b0}};
      key_valid_r <= 1'b0;
      key_code_r  <= {KEY_W{1'b0}};
      key_held_r  <= 1'b0;
      multi_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rcnt_r      <= rcnt_nxt_s;
      rep_phase_r <= rep_phase_nxt_s;
      cand_r      <= cand_nxt_s;
      key_valid_r <= key_valid_nxt_s;
      key_code_r  <= key_code_nxt_s;
      key_held_r  <= key_held_nxt_s;
      multi_err_r <= !one_s && !none_s;
    end
  end

  assign kp.key_valid = key_valid_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_held  = key_held_r;
  assign kp.multi_err = multi_err_r;

endmodule

// File: tb/tb_keypad_debouncer.sv
// ---------------------------------------------------------------------------
// tb_keypad_debouncer
// Directed bench for keypad_debouncer with default parameters
// (DEBOUNCE_CYCLES=3, REPEAT_DELAY=50, REPEAT_RATE=10). Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_keypad_debouncer;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   pulses;
  int   adjacent;
  logic prev_valid;
  int   seg;

  keypad_debouncer_if kif ();

  keypad_debouncer #(
    .DEBOUNCE_CYCLES (3),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (50),
    .REPEAT_RATE     (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle to the falling edge, tallying strobes.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        pulses++;
        if (prev_valid) adjacent++;
      end
      prev_valid = (kif.key_valid === 1'b1);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int n);
    kif.pb = 20'h00001 << n;
  endtask

  initial begin
    vectors = 0; miscompares = 0; pulses = 0; adjacent = 0; prev_valid = 1'b0;
    reset  = 1'b1;
    kif.pb = 20'h00000;
    tick(3);
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_code",  32'(kif.key_code),  32'd0);
    check("rst_held",  32'(kif.key_held),  32'd0);
    check("rst_multi", 32'(kif.multi_err), 32'd0);
    reset = 1'b0;
    tick(2);

    // Clean press of pb[7] for 10 cycles.
    seg = pulses;
    press(7);
    tick(4);
    check("clean_early", 32'(kif.key_valid), 32'd0);
    tick(1);
    check("clean_valid", 32'(kif.key_valid), 32'd1);
    check("clean_code",  32'(kif.key_code),  32'h07);
    check("clean_held",  32'(kif.key_held),  32'd1);
    tick(1);
    check("clean_one_cycle", 32'(kif.key_valid), 32'd0);
    tick(4);
    kif.pb = 20'h00000;
    tick(4);
    check("clean_held_late", 32'(kif.key_held), 32'd1);
    tick(1);
    check("clean_held_fall", 32'(kif.key_held), 32'd0);
    check("clean_count", 32'(pulses - seg), 32'd1);
    check("clean_code_hold", 32'(kif.key_code), 32'h07);
    tick(3);

    // Press bounce on pb[3]: 1,0,1 then held.
    seg = pulses;
    press(3);
    tick(1);
    kif.pb = 20'h00000;
    tick(1);
    press(3);
    tick(4);
    check("bounce_none_yet", 32'(pulses - seg), 32'd0);
    tick(1);
    check("bounce_valid", 32'(kif.key_valid), 32'd1);
    check("bounce_code",  32'(kif.key_code),  32'h03);
    tick(6);
    kif.pb = 20'h00000;
    tick(8);
    check("bounce_count", 32'(pulses - seg), 32'd1);

    // Two keys together: no event, multi_err one cycle after pb_s.
    seg = pulses;
    kif.pb = 20'h00006;
    tick(2);
    check("multi_lag", 32'(kif.multi_err), 32'd0);
    tick(1);
    check("multi_set", 32'(kif.multi_err), 32'd1);
    tick(6);
    check("multi_no_event", 32'(pulses - seg), 32'd0);
    check("multi_no_held",  32'(kif.key_held),  32'd0);
    kif.pb = 20'h00000;
    tick(3);
    check("multi_clear", 32'(kif.multi_err), 32'd0);
    tick(2);

    // Extra key pb[9] while pb[4] held.
    seg = pulses;
    press(4);
    tick(5);
    check("extra_valid", 32'(kif.key_valid), 32'd1);
    check("extra_code",  32'(kif.key_code),  32'h04);
    kif.pb = 20'h00210;
    tick(3);
    check("extra_multi", 32'(kif.multi_err), 32'd1);
    tick(7);
    check("extra_held",  32'(kif.key_held), 32'd1);
    check("extra_count", 32'(pulses - seg), 32'd1);
    kif.pb = 20'h00000;
    tick(8);
    check("extra_release", 32'(kif.key_held), 32'd0);

    // Auto-repeat of digit pb[5].
    seg = pulses;
    press(5);
    tick(5);
    check("rep_first", 32'(kif.key_valid), 32'd1);
    for (int k = 1; k <= 85; k++) begin
      tick(1);
      check($sformatf("rep_k%0d", k), 32'(kif.key_valid),
            32'((k == 50) || (k == 60) || (k == 70) || (k == 80)));
    end
    kif.pb = 20'h00000;
    tick(8);
    check("rep_count", 32'(pulses - seg), 32'd5);
    check("rep_code",  32'(kif.key_code), 32'h05);
    check("rep_released", 32'(kif.key_held), 32'd0);

    // ENTER never repeats.
    seg = pulses;
    press(16);
    tick(85);
    check("enter_count", 32'(pulses - seg), 32'd1);
    check("enter_code",  32'(kif.key_code), 32'h10);
    kif.pb = 20'h00000;
    tick(8);

    // Release bounce on pb[12].
    seg = pulses;
    press(12);
    tick(5);
    check("relb_valid", 32'(kif.key_valid), 32'd1);
    tick(3);
    kif.pb = 20'h00000;
    tick(2);
    press(12);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("relb_held", 32'(kif.key_held), 32'd1);
    end
    check("relb_count", 32'(pulses - seg), 32'd1);
    kif.pb = 20'h00000;
    tick(8);

    // Reset while pb[0] held, then a fresh press after release of reset.
    seg = pulses;
    press(0);
    tick(5);
    check("rsth_valid", 32'(kif.key_valid), 32'd1);
    tick(2);
    check("rsth_held_pre", 32'(kif.key_held), 32'd1);
    reset = 1'b1;
    #1;
    check("rsth_held",  32'(kif.key_held),  32'd0);
    check("rsth_valid0", 32'(kif.key_valid), 32'd0);
    check("rsth_code",  32'(kif.key_code),  32'd0);
    check("rsth_multi", 32'(kif.multi_err), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(4);
    check("rsth_early", 32'(kif.key_valid), 32'd0);
    tick(1);
    check("rsth_fresh",      32'(kif.key_valid), 32'd1);
    check("rsth_fresh_code", 32'(kif.key_code),  32'h00);
    check("rsth_fresh_held", 32'(kif.key_held),  32'd1);
    kif.pb = 20'h00000;
    tick(8);
    check("rsth_count", 32'(pulses - seg), 32'd2);

    check("no_adjacent", 32'(adjacent), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
